// File: rtl/lfsr_lockstep_monitor.sv
// XNOR Fibonacci LFSR with echo-bit tamper check and a 3-state alarm FSM.
// Define LFSR_SHADOW_EN to add a redundant lockstep shadow register whose divergence also raises the alarm.
module lfsr_lockstep_monitor #(
    parameter int          NUM_BITS     = 16,
    parameter logic [31:0] TAP_MASK     = 32'h0000_D008,
    parameter int          ALARM_THRESH = 2
) (
    input  logic                i_Clk,
    input  logic                i_rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    input  logic                i_Ext_Valid,
    input  logic                i_Ext_Bit,
    input  logic                master_key_ready,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Done,
    output logic                o_seed_err,
    output logic                o_alarm,
    output logic [7:0]          o_mismatch_cnt,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic [NUM_BITS-1:0] TAPS        = TAP_MASK[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0] ALL_ONES    = '1;
    localparam logic [NUM_BITS-1:0] PERIOD_LAST = {{(NUM_BITS-1){1'b1}}, 1'b0};
    localparam logic [7:0]          THRESH      = 8'(ALARM_THRESH);

    state_t              state_reg, state_next;
    logic [NUM_BITS-1:0] lfsr_reg, lfsr_next;
    logic [NUM_BITS-1:0] period_reg, period_next;
    logic [7:0]          mis_cnt_reg, mis_cnt_next;
    logic                done_reg, done_next;
    logic                seed_err_reg, seed_err_next;
    logic                alarm_reg, alarm_next;

    logic [NUM_BITS-1:0] lfsr_tapped;
    logic                lfsr_fb;
    logic                seed_req, seed_ok, do_step, do_clear;
    logic                shadow_diverged;

    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_taps
            assign lfsr_tapped[gi] = lfsr_reg[gi] & TAPS[gi];
        end
    endgenerate
    assign lfsr_fb = ~^lfsr_tapped;

    assign seed_req = i_Enable & i_Seed_DV & (state_reg != ST_ALARM);
    assign seed_ok  = seed_req & (i_Seed_Data != ALL_ONES);
    assign do_step  = i_Enable & ~i_Seed_DV & (state_reg == ST_RUN);
    assign do_clear = master_key_ready & (state_reg == ST_ALARM);

`ifdef LFSR_SHADOW_EN
    // Independent copy with its own feedback path so a fault in either register is visible.
    logic [NUM_BITS-1:0] shadow_reg, shadow_next;
    logic [NUM_BITS-1:0] shadow_tapped;
    logic                shadow_fb;

    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_shadow_taps
            assign shadow_tapped[gi] = shadow_reg[gi] & TAPS[gi];
        end
    endgenerate
    assign shadow_fb       = ~^shadow_tapped;
    assign shadow_diverged = (shadow_reg != lfsr_reg);

    always_comb begin
        shadow_next = shadow_reg;
        if (seed_ok) begin
            shadow_next = i_Seed_Data;
        end else if (do_step) begin
            shadow_next = {shadow_reg[NUM_BITS-2:0], shadow_fb};
        end else if (do_clear) begin
            shadow_next = lfsr_reg;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            shadow_reg <= '0;
        end else begin
            shadow_reg <= shadow_next;
        end
    end
`else
    assign shadow_diverged = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        lfsr_next     = lfsr_reg;
        period_next   = period_reg;
        mis_cnt_next  = mis_cnt_reg;
        done_next     = 1'b0;
        seed_err_next = seed_req & ~seed_ok;

        if (seed_ok) begin
            lfsr_next = i_Seed_Data;
        end else if (do_step) begin
            lfsr_next = {lfsr_reg[NUM_BITS-2:0], lfsr_fb};
        end

        // Done pulse counts steps only, so it fires even for non-maximal tap masks.
        if (seed_ok) begin
            period_next = '0;
        end else if (do_step) begin
            if (period_reg == PERIOD_LAST) begin
                period_next = '0;
                done_next   = 1'b1;
            end else begin
                period_next = period_reg + 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (seed_ok) begin
                    mis_cnt_next = '0;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (seed_ok) begin
                    mis_cnt_next = '0;
                end else begin
                    if (i_Ext_Valid) begin
                        if (i_Ext_Bit != lfsr_reg[0]) begin
                            mis_cnt_next = (mis_cnt_reg == 8'hFF) ? mis_cnt_reg : mis_cnt_reg + 8'd1;
                        end else begin
                            mis_cnt_next = '0;
                        end
                    end
                    if ((mis_cnt_next >= THRESH) || shadow_diverged) begin
                        state_next = ST_ALARM;
                    end
                end
            end
            ST_ALARM: begin
                if (do_clear) begin
                    mis_cnt_next = '0;
                    state_next   = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        alarm_next = (state_next == ST_ALARM);
    end

    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            lfsr_reg     <= '0;
            period_reg   <= '0;
            mis_cnt_reg  <= '0;
            done_reg     <= 1'b0;
            seed_err_reg <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lfsr_reg     <= lfsr_next;
            period_reg   <= period_next;
            mis_cnt_reg  <= mis_cnt_next;
            done_reg     <= done_next;
            seed_err_reg <= seed_err_next;
            alarm_reg    <= alarm_next;
        end
    end

    assign o_LFSR_Data    = lfsr_reg;
    assign o_LFSR_Done    = done_reg;
    assign o_seed_err     = seed_err_reg;
    assign o_alarm        = alarm_reg;
    assign o_mismatch_cnt = mis_cnt_reg;
    assign o_state        = state_reg;

endmodule
